// File: rtl/io_event_fifo.sv
// Collects single-cycle button/rotary pulses into per-source pending bits and queues them, lowest source first, as 3-bit codes.
// Pulse-to-valid latency is 2 cycles; a full FIFO holds pending bits, and a repeat pulse on a still-pending source sets sticky overflow.
module io_event_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    compass_buttons,
    input  logic          rotary_push,
    input  logic          rotary_event,
    input  logic          rotary_left,
    input  logic          event_ready,
    input  logic          overflow_clr,
    output logic          event_valid,
    output logic [2:0]    event_code,
    output logic [CW-1:0] event_count,
    output logic          overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    src;
    logic [7:0]    pending;
    logic [7:0]    push_mask;
    logic [7:0]    pending_next;
    logic [2:0]    push_code;
    logic          push;
    logic          pop;
    logic          can_push;
    logic          merge_loss;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    mem [DEPTH];

    // Bit position is the event code.
    assign src = {rotary_event & rotary_left, rotary_event & ~rotary_left,
                  rotary_push, compass_buttons};

    assign event_valid = (event_count != '0);
    assign pop         = event_valid & event_ready;
    assign can_push    = (event_count != FULL_COUNT) | pop;
    assign event_code  = mem[rd_ptr];

    always_comb begin
        push_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                push_code = 3'(i);
            end
        end
    end

    assign push      = (|pending) & can_push;
    assign push_mask = push ? (8'd1 << push_code) : 8'd0;

    // A pulse on the bit being pushed this cycle re-arms it instead of being lost.
    assign merge_loss   = |(src & pending & ~push_mask);
    assign pending_next = (pending & ~push_mask) | src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            event_count <= '0;
            overflow    <= 1'b0;
        end else begin
            pending <= pending_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   event_count <= event_count + CW'(1);
                2'b01:   event_count <= event_count - CW'(1);
                default: event_count <= event_count;
            endcase
            if (merge_loss) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_code;
        end
    end
endmodule

// File: tb/tb_io_event_fifo.sv
// Directed and random stimulus for io_event_fifo, checked every cycle against a queue-based reference model.
module tb_io_event_fifo;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [4:0]    compass_buttons;
    logic          rotary_push;
    logic          rotary_event;
    logic          rotary_left;
    logic          event_ready;
    logic          overflow_clr;
    logic          event_valid;
    logic [2:0]    event_code;
    logic [CW-1:0] event_count;
    logic          overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending flags per source, FIFO as a queue of codes.
    int q[$];
    bit mpend[8];
    bit movf;

    io_event_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .compass_buttons (compass_buttons),
        .rotary_push     (rotary_push),
        .rotary_event    (rotary_event),
        .rotary_left     (rotary_left),
        .event_ready     (event_ready),
        .overflow_clr    (overflow_clr),
        .event_valid     (event_valid),
        .event_code      (event_code),
        .event_count     (event_count),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) mpend[i] = 1'b0;
        movf = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] s, input logic rdy, input logic oc);
        bit pop_now;
        bit lost;
        int pushed;
        pop_now = (q.size() != 0) && rdy;
        pushed  = -1;
        if (q.size() < DEPTH || pop_now) begin
            for (int i = 0; i < 8; i++) begin
                if (mpend[i] && pushed < 0) pushed = i;
            end
        end
        lost = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (s[i] && mpend[i] && i != pushed) lost = 1'b1;
        end
        if (pop_now) void'(q.pop_front());
        if (pushed >= 0) begin
            q.push_back(pushed);
            mpend[pushed] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (s[i]) mpend[i] = 1'b1;
        end
        if (lost) movf = 1'b1;
        else if (oc) movf = 1'b0;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(event_valid), 32'(q.size() != 0));
        chk("count", 32'(event_count), 32'(q.size()));
        if (q.size() != 0) chk("code", 32'(event_code), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic set_idle();
        compass_buttons = 5'd0;
        rotary_push     = 1'b0;
        rotary_event    = 1'b0;
        rotary_left     = 1'b0;
        event_ready     = 1'b0;
        overflow_clr    = 1'b0;
    endtask

    // Called and returns at a falling edge; one full clock cycle per call.
    task automatic cyc(input logic [4:0] cb, input logic rp, input logic re,
                       input logic rl, input logic rdy, input logic oc);
        check_outputs();
        compass_buttons = cb;
        rotary_push     = rp;
        rotary_event    = re;
        rotary_left     = rl;
        event_ready     = rdy;
        overflow_clr    = oc;
        model_step({re & rl, re & ~rl, rp, cb}, rdy, oc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) cyc(5'd0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        compass_buttons = 5'h1f;
        rotary_push     = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(event_valid), 32'd0);
        chk("reset_count", 32'(event_count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        set_idle();
        rst = 1'b0;

        // Single event latency
        cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("lat_valid", 32'(event_valid), 32'd1);
        chk("lat_code", 32'(event_code), 32'd2);
        chk("lat_count", 32'(event_count), 32'd1);
        idle(3, 1'b1);

        // Simultaneous sources pushed in priority order on consecutive cycles
        cyc(5'b00001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("prio_count1", 32'(event_count), 32'd1);
        idle(1, 1'b0);
        chk("prio_count2", 32'(event_count), 32'd2);
        idle(1, 1'b0);
        chk("prio_count3", 32'(event_count), 32'd3);
        chk("prio_head0", 32'(event_code), 32'd0);
        chk("prio_overflow", 32'(overflow), 32'd0);
        idle(1, 1'b1);
        chk("prio_head5", 32'(event_code), 32'd5);
        idle(1, 1'b1);
        chk("prio_head7", 32'(event_code), 32'd7);
        idle(1, 1'b1);
        chk("prio_empty", 32'(event_valid), 32'd0);

        // Fill to DEPTH, ninth event waits in pending
        cyc(5'h1f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);
        cyc(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("full_count", 32'(event_count), 32'(DEPTH));
        chk("full_overflow", 32'(overflow), 32'd0);
        idle(1, 1'b1);
        chk("full_pushpop_count", 32'(event_count), 32'(DEPTH));
        chk("full_pushpop_head", 32'(event_code), 32'd1);

        // Full FIFO streaming with pending events
        cyc(5'b01100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1, 1'b1);
            chk("stream_count", 32'(event_count), 32'(DEPTH));
        end
        chk("stream_head", 32'(event_code), 32'd4);
        idle(12, 1'b1);

        // Overflow set, clear, and clear racing a new merge
        cyc(5'h1f, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);
        cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("backpressure_no_ovf", 32'(overflow), 32'd0);
        cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'd0);
        cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear_race", 32'(overflow), 32'd1);
        cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(12, 1'b1);

        // Random traffic: mostly-stalled consumer, then mostly-ready
        for (int k = 0; k < 600; k++) begin
            logic [4:0] cb;
            logic rp, re, rl, rdy, oc;
            cb  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            rp  = ($urandom_range(0, 7) == 0);
            re  = ($urandom_range(0, 5) == 0);
            rl  = 1'($urandom_range(0, 1));
            rdy = (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            oc  = ($urandom_range(0, 15) == 0);
            cyc(cb, rp, re, rl, rdy, oc);
        end
        idle(16, 1'b1);

        // Asynchronous reset mid-cycle with entries and pending bits in flight
        cyc(5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        cyc(5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(event_count), 32'd5);
        chk("pre_rst_overflow", 32'(overflow), 32'd1);
        set_idle();
        #2;
        rst = 1'b1;
        compass_buttons = 5'h1f;
        rotary_push     = 1'b1;
        #1;
        chk("async_rst_valid", 32'(event_valid), 32'd0);
        chk("async_rst_count", 32'(event_count), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        idle(4, 1'b1);
        cyc(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("post_rst_code", 32'(event_code), 32'd4);
        chk("post_rst_count", 32'(event_count), 32'd1);
        idle(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/io_event_fifo.md
IO_EVENT_FIFO -- requirements
Module: io_event_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, width of event_count.
REQ-003 clk  input  1  single clock, CPU clock domain; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 compass_buttons  input  5  debounced single-cycle pulses: bit0 center, bit1 east, bit2 north, bit3 south, bit4 west.
REQ-006 rotary_push  input  1  debounced single-cycle pulse.
REQ-007 rotary_event  input  1  single-cycle pulse, one detent turned.
REQ-008 rotary_left  input  1  direction, meaningful only while rotary_event=1 (1 = left).
REQ-009 event_ready  input  1  consumer accepts the head entry.
REQ-010 overflow_clr  input  1  clears the overflow flag.
REQ-011 event_valid  output  1  FIFO non-empty.
REQ-012 event_code  output  3  head entry code.
REQ-013 event_count  output  CW  entries held, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag: an event was lost.

Function
REQ-015 Source index / code mapping SHALL be: 0..4 = compass bits 0..4, 5 = rotary_push, 6 = rotary right (rotary_event & ~rotary_left), 7 = rotary left (rotary_event & rotary_left).
REQ-016 Stage 1: an 8-bit pending register SHALL set bit i on the clock edge after source i pulses.
REQ-017 Stage 2: each cycle, if any pending bit is set and a push is permitted, the lowest-index set bit SHALL be written to the FIFO as its code and that bit cleared; at most one push per cycle.
REQ-018 Push SHALL be permitted when event_count < DEPTH, or when event_count == DEPTH and a pop occurs in the same cycle.
REQ-019 A pending bit cleared by a push while the same source pulses in that cycle SHALL remain set; the new event is not lost.
REQ-020 A pulse on a source whose pending bit is set and not being pushed that cycle SHALL set overflow on the next edge; the pulse is merged and lost.
REQ-021 While the FIFO is full with no pop, pending bits SHALL hold; this backpressure alone SHALL NOT set overflow.
REQ-022 Pop SHALL occur iff event_valid & event_ready; event_ready while event_valid=0 SHALL have no effect.
REQ-023 event_valid = (event_count != 0); event_code SHALL be the oldest entry and stable until popped; event_code is don't-care while event_valid=0.
REQ-024 Simultaneous push and pop: event_count SHALL stay unchanged and order SHALL be preserved, at any occupancy including DEPTH.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; event_count SHALL never exceed DEPTH or go below 0.
REQ-026 Latency: a pulse in cycle N with an empty FIFO and no other pending bits SHALL give event_valid=1 with the matching code in cycle N+2.
REQ-027 overflow SHALL clear on the edge after overflow_clr=1, unless a new overflow condition occurs in that same cycle, in which case it SHALL stay set.
REQ-028 FIFO storage SHALL be written only on push and SHALL need no reset.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force: pending=0, pointers=0, event_count=0, event_valid=0, overflow=0.
REQ-030 Pulses present during rst SHALL be ignored; events in flight at reset assertion SHALL be discarded.
REQ-031 The first pulse accepted after release SHALL be one sampled on or after the first clock edge with rst=0.

Verification
REQ-032 Reset, then pulse compass_buttons=5'b00100 in cycle N, event_ready=0 -> event_valid=1 and event_code=2 in cycle N+2; event_count=1.
REQ-033 Same cycle: compass bit0 pulse, rotary_push pulse, and rotary_event with rotary_left=1 -> codes pop in order 0, 5, 7; pushes occur on consecutive cycles; overflow=0.
REQ-034 DEPTH=8, event_ready=0, generate 9 distinct-source events -> event_count=8, source of the 9th stays pending, overflow=0; then one pop -> the 9th is pushed and event_count stays 8.
REQ-035 Full FIFO with event_ready=1 held and pending events -> one push and one pop per cycle, count stays 8, FIFO order equals arrival order.
REQ-036 Pulse east twice while its pending bit is held by a full FIFO -> overflow=1; overflow_clr=1 for one cycle -> overflow=0; overflow_clr together with a fresh merge -> overflow stays 1.
REQ-037 Assert rst asynchronously mid-cycle with count=5 and pending bits set -> outputs go to reset values before the next edge; no stale codes appear after release.
